guess_display: RTL

GUESS_DISPLAY -- requirements
Module: guess_display

---
 rtl/guess_disp_pkg.sv | 15 +
 rtl/seg7_hex_decoder.sv | 30 +++
 rtl/guess_display.sv | 125 ++++++++++++
 3 files changed

// File: rtl/guess_disp_pkg.sv
// Shared types and glyph constants for the guess display block.
package guess_disp_pkg;

  typedef enum logic [1:0] {
    ST_SHOW = 2'd0,
    ST_WIN  = 2'd1,
    ST_LOSE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_ALL  = 7'h7F;
  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_ZERO = 7'h3F;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex digit to 7-segment glyph (active-high, bit0=a .. bit6=g).
module seg7_hex_decoder (
  input  logic [3:0] hex,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = 7'h00;
    case (hex)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = 7'h00;
    endcase
  end

endmodule

// File: rtl/guess_display.sv
// Seven-segment display of the latched guess, with WIN blink and LOSE dash animations.
// Inputs are single-cycle pulses (no handshake); outputs are registered from next-state values.
module guess_display
  import guess_disp_pkg::*;
#(
  parameter int BLINK_HALF   = 4,
  parameter int BLINK_PHASES = 6,
  parameter int LOSE_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] guess_val,
  input  logic       guess_load,
  input  logic       result_valid,
  input  logic       result_match,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy,
  output state_t     dbg_state
);

  localparam int PH_W   = $clog2(BLINK_PHASES + 1);
  localparam int HALF_W = $clog2(BLINK_HALF + 1);
  localparam int LOSE_W = $clog2(LOSE_CYCLES + 1);
  // One cycle timer serves both animations, so it takes the wider of the two sizes.
  localparam int CYC_W  = (HALF_W > LOSE_W) ? HALF_W : LOSE_W;

  state_t            state_q, state_d;
  logic [3:0]        guess_q, guess_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [6:0]        glyph;
  logic [6:0]        seg_d;
  logic              dp_d;
  logic              busy_d;

  seg7_hex_decoder u_dec (
    .hex   (guess_d),
    .glyph (glyph)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SHOW;
      guess_q <= 4'h0;
      phase_q <= '0;
      cyc_q   <= '0;
      seg     <= SEG_ZERO;
      dp      <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      guess_q <= guess_d;
      phase_q <= phase_d;
      cyc_q   <= cyc_d;
      seg     <= seg_d;
      dp      <= dp_d;
      busy    <= busy_d;
    end
  end

  // Results are only acted on in SHOW; during an animation they are dropped.
  always_comb begin
    state_d = state_q;
    guess_d = guess_load ? guess_val : guess_q;
    phase_d = phase_q;
    cyc_d   = cyc_q;
    case (state_q)
      ST_SHOW: begin
        if (result_valid) begin
          phase_d = '0;
          cyc_d   = '0;
          state_d = result_match ? ST_WIN : ST_LOSE;
        end
      end
      ST_WIN: begin
        if (cyc_q == CYC_W'(BLINK_HALF - 1)) begin
          cyc_d = '0;
          if (phase_q == PH_W'(BLINK_PHASES - 1)) begin
            phase_d = '0;
            state_d = ST_SHOW;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_LOSE: begin
        if (cyc_q == CYC_W'(LOSE_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = ST_SHOW;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: state_d = ST_SHOW;
    endcase
  end

  always_comb begin
    seg_d  = glyph;
    dp_d   = 1'b0;
    busy_d = 1'b0;
    case (state_d)
      ST_WIN: begin
        seg_d  = phase_d[0] ? SEG_OFF : SEG_ALL;
        dp_d   = 1'b1;
        busy_d = 1'b1;
      end
      ST_LOSE: begin
        seg_d  = SEG_DASH;
        busy_d = 1'b1;
      end
      default: begin
        seg_d  = glyph;
        dp_d   = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign dbg_state = state_q;

endmodule
